// File: rtl/proc_src_arrayed_sym_deser.sv
// Serial 2-bit symbol deserializer feeding a four-lane frame handshake.
// Optional DESER_OVERLAP_EN lets the first symbol of the next frame enter during handoff.
module proc_src_arrayed_sym_deser #(
  parameter int SYM_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] data_1,
  output logic [SYM_W-1:0] data_2,
  output logic [SYM_W-1:0] data_3,
  output logic [SYM_W-1:0] data_4,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [SYM_W-1:0] sym_mem_q [0:3];
  logic [SYM_W-1:0] sym_mem_d [0:3];
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             accept;
  logic             handoff;

  always_comb begin
    in_ready = (state_q == FILL);
`ifdef DESER_OVERLAP_EN
    if (state_q == HOLD) begin
      in_ready = out_ready;
    end
`endif
    out_valid = (state_q == HOLD);
    accept    = in_valid && in_ready;
    handoff   = out_valid && out_ready;
  end

  // clr takes priority over both symbol capture and frame handoff
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < 4; i++) begin
      sym_mem_d[i] = sym_mem_q[i];
    end
    if (clr) begin
      state_d = FILL;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            sym_mem_d[idx_q] = in_sym;
            idx_d            = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (handoff) begin
            state_d     = FILL;
            idx_d       = 2'd0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
`ifdef DESER_OVERLAP_EN
            if (accept) begin
              sym_mem_d[0] = in_sym;
              idx_d        = 2'd1;
            end
`endif
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= 2'd0;
      frame_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        sym_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < 4; i++) begin
        sym_mem_q[i] <= sym_mem_d[i];
      end
    end
  end

  assign data_1    = sym_mem_q[0];
  assign data_2    = sym_mem_q[1];
  assign data_3    = sym_mem_q[2];
  assign data_4    = sym_mem_q[3];
  assign frame_cnt = frame_cnt_q;

endmodule
